// File: rtl/subckt_probe_sequencer.sv
// Test sequencer: flushes a subcircuit, applies vectors, checks its output.
// Optional first-fail index capture: define PROBE_FIRST_FAIL_EN.
module subckt_probe_sequencer #(
    parameter int NVEC      = 16,
    parameter int LAT       = 2,
    parameter int FLUSH_CYC = 4
) (
    input  logic       I1470_clk,
    input  logic       I1477_rst,
    input  logic       start,
    input  logic       abort,
    input  logic       vec_valid,
    input  logic [4:0] vec_data,
    input  logic       vec_exp,
    output logic       vec_ready,
    output logic [4:0] dut_in,
    output logic       dut_rst,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] mismatch_cnt,
    output logic [7:0] first_fail_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [7:0] LAST_IDX   = 8'(NVEC - 1);
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYC - 1);
    // With LAT=1 the sample edge is the one right after the handshake.
    localparam logic [3:0] WAIT_LAST  = (LAT > 1) ? 4'(LAT - 2) : 4'd0;
    localparam logic [2:0] S_POST_HS  = (LAT > 1) ? S_WAIT : S_CHECK;

    logic [2:0] state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       exp_q, exp_d;
    logic       pass_q, pass_d;
    logic [7:0] mm_q, mm_d;
    logic [4:0] din_q, din_d;
    logic       drst_q, drst_d;
    logic       run_start;
    logic       miss;

    assign run_start = (state_q == S_IDLE) && start && !abort;
    assign miss      = (dut_out != exp_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        pass_d  = pass_q;
        mm_d    = mm_q;
        din_d   = din_q;
        drst_d  = drst_q;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            drst_d  = 1'b1;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    drst_d = 1'b0;
                    if (run_start) begin
                        state_d = S_FLUSH;
                        drst_d  = 1'b1;
                        mm_d    = 8'd0;
                        idx_d   = 8'd0;
                        cnt_d   = 4'd0;
                        pass_d  = 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == FLUSH_LAST) begin
                        state_d = S_ISSUE;
                        drst_d  = 1'b0;
                        din_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_ISSUE: begin
                    if (vec_valid) begin
                        din_d   = vec_data;
                        exp_d   = vec_exp;
                        cnt_d   = 4'd0;
                        state_d = S_POST_HS;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (miss && (mm_q != 8'hFF)) begin
                        mm_d = mm_q + 8'd1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        pass_d  = (mm_d == 8'd0);
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_ISSUE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            state_q <= S_IDLE;
            idx_q   <= 8'd0;
            cnt_q   <= 4'd0;
            exp_q   <= 1'b0;
            pass_q  <= 1'b0;
            mm_q    <= 8'd0;
            din_q   <= 5'd0;
            drst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
            mm_q    <= mm_d;
            din_q   <= din_d;
            drst_q  <= drst_d;
        end
    end

`ifdef PROBE_FIRST_FAIL_EN
    logic [7:0] ffi_q, ffi_d;

    always_comb begin
        ffi_d = ffi_q;
        if (run_start) begin
            ffi_d = 8'hFF;
        end else if ((state_q == S_CHECK) && !abort && miss && (mm_q == 8'd0)) begin
            ffi_d = idx_q;
        end
    end

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            ffi_q <= 8'hFF;
        end else begin
            ffi_q <= ffi_d;
        end
    end

    assign first_fail_idx = ffi_q;
`else
    assign first_fail_idx = 8'hFF;
`endif

    assign vec_ready    = (state_q == S_ISSUE) && !abort;
    assign dut_in       = din_q;
    assign dut_rst      = drst_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign pass         = pass_q;
    assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_subckt_probe_sequencer.sv
// Directed bench: NVEC=4 instance for run scenarios, NVEC=256 instance
// for saturation; the subcircuit is a parity function with one flop.
module tb_subckt_probe_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    logic vec_valid = 1'b0;
    logic [4:0] vec_data = 5'd0;
    logic vec_exp = 1'b0;
    logic start_s = 1'b0;
    logic start_b = 1'b0;

    logic       s_vec_ready, s_dut_rst, s_busy, s_done, s_pass;
    logic [4:0] s_dut_in;
    logic [7:0] s_mm, s_ffi;
    logic       s_dut_out = 1'b0;

    logic       b_vec_ready, b_dut_rst, b_busy, b_done, b_pass;
    logic [4:0] b_dut_in;
    logic [7:0] b_mm, b_ffi;
    logic       b_dut_out = 1'b0;

    int nasrt = 0;
    int nfail = 0;

    logic [4:0] VEC [4] = '{5'h00, 5'h1F, 5'h0A, 5'h15};

`ifdef PROBE_FIRST_FAIL_EN
    localparam logic [7:0] FFI_V1  = 8'd1;
    localparam logic [7:0] FFI_BIG = 8'd0;
`else
    localparam logic [7:0] FFI_V1  = 8'hFF;
    localparam logic [7:0] FFI_BIG = 8'hFF;
`endif

    always #5 clk = ~clk;

    // LAT=2: output valid one edge after dut_in changes, sampled on the next
    always @(posedge clk) s_dut_out <= ^s_dut_in;
    always @(posedge clk) b_dut_out <= ^b_dut_in;

    subckt_probe_sequencer #(.NVEC(4), .LAT(2), .FLUSH_CYC(4)) u_dut (
        .I1470_clk(clk), .I1477_rst(rst), .start(start_s), .abort(abort),
        .vec_valid(vec_valid), .vec_data(vec_data), .vec_exp(vec_exp),
        .vec_ready(s_vec_ready), .dut_in(s_dut_in), .dut_rst(s_dut_rst),
        .dut_out(s_dut_out), .busy(s_busy), .done(s_done), .pass(s_pass),
        .mismatch_cnt(s_mm), .first_fail_idx(s_ffi)
    );

    subckt_probe_sequencer #(.NVEC(256), .LAT(2), .FLUSH_CYC(4)) u_big (
        .I1470_clk(clk), .I1477_rst(rst), .start(start_b), .abort(abort),
        .vec_valid(vec_valid), .vec_data(vec_data), .vec_exp(vec_exp),
        .vec_ready(b_vec_ready), .dut_in(b_dut_in), .dut_rst(b_dut_rst),
        .dut_out(b_dut_out), .busy(b_busy), .done(b_done), .pass(b_pass),
        .mismatch_cnt(b_mm), .first_fail_idx(b_ffi)
    );

    // Drives one 4-vector run on the small instance and reports what it saw.
    task automatic run_small(input logic [3:0] inv, input bit hold,
                             input int stall_k, input logic [7:0] stall_mm,
                             output int hs, output int nd, output int rc,
                             output int stall_rdy, output int stall_bad,
                             output bit to);
        int k = 0;
        int tail = 0;
        int st = 0;
        bit seen = 0;
        nd = 0; rc = 0; stall_rdy = 0; stall_bad = 0;
        start_s = 1'b1;
        vec_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!hold) start_s = 1'b0;
            if (s_done) begin nd++; seen = 1; start_s = 1'b0; end
            if (s_dut_rst) rc++;
            vec_valid = 1'b0;
            if (k == stall_k && s_vec_ready && st == 0) st = 1;
            if (st >= 1 && st <= 10) begin
                if (s_vec_ready) stall_rdy++;
                if (s_dut_in !== VEC[stall_k-1] || s_mm !== stall_mm) stall_bad++;
                st++;
            end else if (s_vec_ready && k < 4) begin
                vec_valid = 1'b1;
                vec_data = VEC[k];
                vec_exp = (^VEC[k]) ^ inv[k];
                k++;
            end
            if (seen) begin
                tail++;
                if (tail > 5) break;
            end
        end
        hs = k;
        to = !seen;
        start_s = 1'b0;
        vec_valid = 1'b0;
    endtask

    // Waits (bounded) for vec_ready, hands over one vector, returns in WAIT.
    task automatic feed_one(input logic [4:0] d, input logic e, output bit to);
        to = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_vec_ready) begin
                vec_valid = 1'b1; vec_data = d; vec_exp = e; to = 0;
                break;
            end
        end
        @(negedge clk);
        vec_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nasrt++; if (s_busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %0d, expected 0", s_busy); end
        nasrt++; if (s_done !== 1'b0) begin nfail++; $display("FAIL reset_done: got %0d, expected 0", s_done); end
        nasrt++; if (s_pass !== 1'b0) begin nfail++; $display("FAIL reset_pass: got %0d, expected 0", s_pass); end
        nasrt++; if (s_vec_ready !== 1'b0) begin nfail++; $display("FAIL reset_ready: got %0d, expected 0", s_vec_ready); end
        nasrt++; if (s_mm !== 8'd0) begin nfail++; $display("FAIL reset_mm: got %0d, expected 0", s_mm); end
        nasrt++; if (s_dut_in !== 5'd0) begin nfail++; $display("FAIL reset_dut_in: got %0h, expected 0", s_dut_in); end
        nasrt++; if (s_dut_rst !== 1'b1) begin nfail++; $display("FAIL reset_dut_rst: got %0d, expected 1", s_dut_rst); end
        nasrt++; if (s_ffi !== 8'hFF) begin nfail++; $display("FAIL reset_ffi: got %0h, expected ff", s_ffi); end
        rst = 1'b0;
        @(negedge clk);
        nasrt++; if (s_dut_rst !== 1'b0) begin nfail++; $display("FAIL reset_release_dut_rst: got %0d, expected 0", s_dut_rst); end
    endtask

    task automatic test_golden();
        int hs, nd, rc, sr, sb; bit to;
        run_small(4'b0000, 0, 99, 8'd0, hs, nd, rc, sr, sb, to);
        nasrt++; if (to !== 1'b0) begin nfail++; $display("FAIL golden_timeout: got %0d, expected 0", to); end
        nasrt++; if (hs != 4) begin nfail++; $display("FAIL golden_handshakes: got %0d, expected 4", hs); end
        nasrt++; if (nd != 1) begin nfail++; $display("FAIL golden_done_pulses: got %0d, expected 1", nd); end
        nasrt++; if (rc != 4) begin nfail++; $display("FAIL golden_flush_cycles: got %0d, expected 4", rc); end
        nasrt++; if (s_mm !== 8'd0) begin nfail++; $display("FAIL golden_mm: got %0d, expected 0", s_mm); end
        nasrt++; if (s_pass !== 1'b1) begin nfail++; $display("FAIL golden_pass: got %0d, expected 1", s_pass); end
        nasrt++; if (s_ffi !== 8'hFF) begin nfail++; $display("FAIL golden_ffi: got %0h, expected ff", s_ffi); end
        nasrt++; if (s_busy !== 1'b0) begin nfail++; $display("FAIL golden_busy: got %0d, expected 0", s_busy); end
    endtask

    task automatic test_mismatch();
        int hs, nd, rc, sr, sb; bit to;
        run_small(4'b1010, 0, 99, 8'd0, hs, nd, rc, sr, sb, to);
        nasrt++; if (hs != 4 || nd != 1 || to) begin nfail++; $display("FAIL mism_run: got hs=%0d done=%0d to=%0d, expected 4 1 0", hs, nd, to); end
        nasrt++; if (s_mm !== 8'd2) begin nfail++; $display("FAIL mism_mm: got %0d, expected 2", s_mm); end
        nasrt++; if (s_pass !== 1'b0) begin nfail++; $display("FAIL mism_pass: got %0d, expected 0", s_pass); end
        nasrt++; if (s_ffi !== FFI_V1) begin nfail++; $display("FAIL mism_ffi: got %0h, expected %0h", s_ffi, FFI_V1); end
    endtask

    task automatic test_stall();
        int hs, nd, rc, sr, sb; bit to;
        run_small(4'b0010, 0, 2, 8'd1, hs, nd, rc, sr, sb, to);
        nasrt++; if (sr != 10) begin nfail++; $display("FAIL stall_ready: got %0d cycles, expected 10", sr); end
        nasrt++; if (sb != 0) begin nfail++; $display("FAIL stall_stable: got %0d bad cycles, expected 0", sb); end
        nasrt++; if (hs != 4 || nd != 1 || to) begin nfail++; $display("FAIL stall_resume: got hs=%0d done=%0d to=%0d, expected 4 1 0", hs, nd, to); end
        nasrt++; if (s_mm !== 8'd1) begin nfail++; $display("FAIL stall_mm: got %0d, expected 1", s_mm); end
    endtask

    task automatic test_abort();
        int hs, nd, rc, sr, sb; bit to, t0, t1, t2;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        feed_one(VEC[0], ^VEC[0], t0);
        feed_one(VEC[1], ^VEC[1], t1);
        feed_one(VEC[2], ^VEC[2], t2);
        nasrt++; if (t0 || t1 || t2 || s_busy !== 1'b1) begin nfail++; $display("FAIL abort_setup: got to=%0d%0d%0d busy=%0d, expected 000 1", t0, t1, t2, s_busy); end
        abort = 1'b1;
        @(negedge clk);
        nasrt++; if (s_busy !== 1'b0) begin nfail++; $display("FAIL abort_busy: got %0d, expected 0", s_busy); end
        nasrt++; if (s_done !== 1'b0) begin nfail++; $display("FAIL abort_done: got %0d, expected 0", s_done); end
        nasrt++; if (s_dut_rst !== 1'b1) begin nfail++; $display("FAIL abort_dut_rst: got %0d, expected 1", s_dut_rst); end
        nasrt++; if (s_pass !== 1'b0) begin nfail++; $display("FAIL abort_pass: got %0d, expected 0", s_pass); end
        start_s = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start_s = 1'b0;
        nasrt++; if (s_busy !== 1'b0 || s_done !== 1'b0) begin nfail++; $display("FAIL abort_wins: got busy=%0d done=%0d, expected 0 0", s_busy, s_done); end
        nasrt++; if (s_dut_rst !== 1'b0) begin nfail++; $display("FAIL abort_rst_one_cycle: got %0d, expected 0", s_dut_rst); end
        run_small(4'b0000, 0, 99, 8'd0, hs, nd, rc, sr, sb, to);
        nasrt++; if (hs != 4 || nd != 1 || to || s_pass !== 1'b1) begin nfail++; $display("FAIL abort_rerun: got hs=%0d done=%0d pass=%0d, expected 4 1 1", hs, nd, s_pass); end
    endtask

    task automatic test_back_to_back();
        int hs, nd, rc, sr, sb; bit to;
        run_small(4'b0000, 1, 99, 8'd0, hs, nd, rc, sr, sb, to);
        nasrt++; if (nd != 1 || to) begin nfail++; $display("FAIL b2b_done_pulses: got %0d, expected 1", nd); end
        nasrt++; if (rc != 4) begin nfail++; $display("FAIL b2b_flush_cycles: got %0d, expected 4", rc); end
        nasrt++; if (hs != 4 || s_pass !== 1'b1) begin nfail++; $display("FAIL b2b_run: got hs=%0d pass=%0d, expected 4 1", hs, s_pass); end
    endtask

    task automatic test_reset_saturate();
        int k = 0;
        int nd = 0;
        int tail = 0;
        bit seen = 0;
        bit t0, t1;
        logic [4:0] d;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        feed_one(VEC[0], ~^VEC[0], t0);
        feed_one(VEC[1], ^VEC[1], t1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nasrt++; if (t0 || t1 || s_busy !== 1'b0 || s_done !== 1'b0 || s_vec_ready !== 1'b0) begin nfail++; $display("FAIL midrst_ctrl: got busy=%0d done=%0d ready=%0d, expected 0 0 0", s_busy, s_done, s_vec_ready); end
        nasrt++; if (s_mm !== 8'd0 || s_pass !== 1'b0) begin nfail++; $display("FAIL midrst_status: got mm=%0d pass=%0d, expected 0 0", s_mm, s_pass); end
        nasrt++; if (s_dut_in !== 5'd0 || s_dut_rst !== 1'b1 || s_ffi !== 8'hFF) begin nfail++; $display("FAIL midrst_dut: got in=%0h rst=%0d ffi=%0h, expected 0 1 ff", s_dut_in, s_dut_rst, s_ffi); end
        start_b = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            vec_valid = 1'b0;
            if (b_done) begin nd++; seen = 1; end
            if (b_vec_ready && k < 256) begin
                d = k[4:0];
                vec_valid = 1'b1;
                vec_data = d;
                vec_exp = ~^d;
                k++;
            end
            if (seen) begin
                tail++;
                if (tail > 3) break;
            end
        end
        vec_valid = 1'b0;
        nasrt++; if (!seen) begin nfail++; $display("FAIL big_timeout: got no done, expected done"); end
        nasrt++; if (k != 256 || nd != 1) begin nfail++; $display("FAIL big_run: got hs=%0d done=%0d, expected 256 1", k, nd); end
        nasrt++; if (b_mm !== 8'd255) begin nfail++; $display("FAIL big_mm_sat: got %0d, expected 255", b_mm); end
        nasrt++; if (b_pass !== 1'b0) begin nfail++; $display("FAIL big_pass: got %0d, expected 0", b_pass); end
        nasrt++; if (b_ffi !== FFI_BIG) begin nfail++; $display("FAIL big_ffi: got %0h, expected %0h", b_ffi, FFI_BIG); end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_mismatch();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule

// File: doc/subckt_probe_sequencer.md
SUBCKT_PROBE_SEQUENCER -- requirements
Module: subckt_probe_sequencer

Interface
REQ-001 Parameter NVEC, default 16: number of vectors per run, range 1..256.
REQ-002 Parameter LAT, default 2: clock edges from DUT input change to valid DUT output, range 1..15.
REQ-003 Parameter FLUSH_CYC, default 4: cycles of DUT reset at run start, range 1..15.
REQ-004 I1470_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 I1477_rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle pulse that begins a run.
REQ-007 abort  in  1  level input that cancels a run.
REQ-008 vec_valid  in  1  stimulus vector available.
REQ-009 vec_data  in  5  stimulus bits for the subcircuit under test (DUT).
REQ-010 vec_exp  in  1  expected DUT output for vec_data.
REQ-011 vec_ready  out  1  sequencer accepts a vector this cycle.
REQ-012 dut_in  out  5  registered drive to the DUT data inputs.
REQ-013 dut_rst  out  1  registered active-high reset to the DUT.
REQ-014 dut_out  in  1  DUT single-bit output.
REQ-015 busy  out  1  run in progress.
REQ-016 done  out  1  one-cycle pulse at run completion.
REQ-017 pass  out  1  last completed run had zero mismatches.
REQ-018 mismatch_cnt  out  8  mismatches in current or last run.
REQ-019 first_fail_idx  out  8  index of the first mismatching vector.

Function
REQ-020 FSM states SHALL be IDLE, FLUSH, ISSUE, WAIT, CHECK and DONE.
REQ-021 IDLE -> FLUSH on start=1 and abort=0: clear mismatch_cnt, clear the vector index, set busy=1, and hold dut_rst=1 for exactly FLUSH_CYC cycles.
REQ-022 FLUSH -> ISSUE: deassert dut_rst and set dut_in=0.
REQ-023 ISSUE: vec_ready=1; a handshake occurs on vec_valid & vec_ready; on handshake, register vec_data into dut_in, latch vec_exp, -> WAIT.
REQ-024 ISSUE with vec_valid=0: hold state and outputs indefinitely; there is no timeout.
REQ-025 vec_ready is 1 only in ISSUE; at most one vector is in flight.
REQ-026 WAIT: dut_in is held stable; count LAT-1 cycles, then -> CHECK, so that dut_out is sampled exactly LAT edges after dut_in changed.
REQ-027 CHECK: if dut_out != latched exp, increment mismatch_cnt, saturating at 255.
REQ-028 CHECK: if vector index = NVEC-1, -> DONE; otherwise increment the index and -> ISSUE.
REQ-029 DONE: for one cycle, done=1, pass=(mismatch_cnt==0), busy=0; then -> IDLE.
REQ-030 pass and mismatch_cnt SHALL hold their values in IDLE until the next start.
REQ-031 start while busy=1 is ignored.
REQ-032 abort=1 in any non-IDLE state -> IDLE next cycle: busy=0, done not pulsed, pass=0, dut_rst=1 for one cycle; abort wins over a simultaneous start.
REQ-033 The vector index SHALL be 8 bits wide and SHALL compare against NVEC-1 without wrap; NVEC=256 completes after index 255.

Reset
REQ-034 I1477_rst=1 SHALL take effect at the next rising edge from any state, mid-run included, and force the state to IDLE.
REQ-035 Reset values: busy=0, done=0, pass=0, vec_ready=0, mismatch_cnt=0, dut_in=0, dut_rst=1, first_fail_idx=8'hFF, index=0.
REQ-036 dut_rst SHALL deassert the cycle after reset is released while in IDLE.

Configuration
REQ-037 Macro PROBE_FIRST_FAIL_EN defined: first_fail_idx is set to 8'hFF at start and captures the vector index at the first mismatching CHECK of a run, then holds.
REQ-038 Macro PROBE_FIRST_FAIL_EN undefined: first_fail_idx is constant 8'hFF and no capture logic is built.

Verification
REQ-039 NVEC=4, LAT=2, golden DUT model, vectors 5'h00,5'h1F,5'h0A,5'h15 with correct vec_exp -> done after 4 handshakes, pass=1, mismatch_cnt=0.
REQ-040 Same run with vec_exp inverted on vectors 1 and 3 -> mismatch_cnt=2, pass=0; with PROBE_FIRST_FAIL_EN, first_fail_idx=1.
REQ-041 vec_valid held low for 10 cycles in ISSUE -> vec_ready stays 1, dut_in unchanged, no CHECK occurs; run resumes when vec_valid goes high.
REQ-042 abort asserted during WAIT of vector 2 -> IDLE next cycle, busy=0, no done pulse, dut_rst=1 for one cycle; a following start yields a full run.
REQ-043 I1477_rst pulsed mid-WAIT, then NVEC=256 with all vec_exp wrong -> after reset all outputs at reset values; mismatch_cnt saturates at 255, done after 256 vectors.
REQ-044 start every cycle during a run -> exactly one done pulse per run, and FLUSH holds dut_rst=1 for exactly FLUSH_CYC cycles.
